// File: rtl/fpu_psc_pkg.sv
// Shared types and constants for the FPU special-case pre-classifier.
package fpu_psc_pkg;

    // Operand class as seen by the special-case rules
    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_e;

    // Result source selected for the downstream datapath
    typedef enum logic [2:0] {
        SEL_NORMAL = 3'd0,
        SEL_ZERO   = 3'd1,
        SEL_INF    = 3'd2,
        SEL_NAN    = 3'd3,
        SEL_PASS_A = 3'd4,
        SEL_PASS_B = 3'd5
    } sel_e;

    localparam logic [1:0] MODE_MUL = 2'd0;
    localparam logic [1:0] MODE_ADD = 2'd1;
    localparam logic [1:0] MODE_SUB = 2'd2;

    // Reserved mode 3 falls back to multiply rules
    function automatic logic is_addsub(input logic [1:0] mode);
        return (mode == MODE_ADD) || (mode == MODE_SUB);
    endfunction

endpackage

// File: rtl/fpu_operand_classify.sv
// Combinational IEEE-754 operand classifier.
// With FPU_PSC_FTZ_EN defined, subnormals classify as ZERO (sign kept) and are
// forwarded with the fraction cleared; otherwise they pass through unchanged.
module fpu_operand_classify
    import fpu_psc_pkg::*;
#(
    parameter int unsigned SIZE_EXP = 8,
    parameter int unsigned SIZE_MAN = 23
) (
    input  logic [SIZE_EXP+SIZE_MAN:0] op_i,
    output cls_e                       cls_c,
    output logic [SIZE_EXP+SIZE_MAN:0] op_c
);

    localparam int unsigned W = 1 + SIZE_EXP + SIZE_MAN;

    logic [SIZE_EXP-1:0] e_fld;
    logic [SIZE_MAN-1:0] m_fld;

    assign e_fld = op_i[W-2 -: SIZE_EXP];
    assign m_fld = op_i[SIZE_MAN-1:0];

    // Decode class from exponent/fraction fields
    always_comb begin
        cls_c = CLS_NORM;
        op_c  = op_i;
        if (e_fld == '0) begin
            if (m_fld == '0) begin
                cls_c = CLS_ZERO;
            end else begin
`ifdef FPU_PSC_FTZ_EN
                cls_c = CLS_ZERO;
                op_c  = {op_i[W-1], {(W-1){1'b0}}};
`else
                cls_c = CLS_SUB;
`endif
            end
        end else if (&e_fld) begin
            cls_c = (m_fld == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fpu_special_case_pipe.sv
// Two-stage valid/ready special-case pre-classifier for FPU MUL and ADD/SUB.
// Stage 1 registers operands and classes, stage 2 registers the selected
// result source, special word and invalid flag. Optional macro FPU_PSC_FTZ_EN
// enables flush-to-zero of subnormal operands.
module fpu_special_case_pipe
    import fpu_psc_pkg::*;
#(
    parameter int unsigned SIZE_EXP = 8,
    parameter int unsigned SIZE_MAN = 23,
    parameter int unsigned TAG_W    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [1:0]                 i_mode,
    input  logic [SIZE_EXP+SIZE_MAN:0] i_op_a,
    input  logic [SIZE_EXP+SIZE_MAN:0] i_op_b,
    input  logic [TAG_W-1:0]           i_tag,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [2:0]                 o_sel,
    output logic [SIZE_EXP+SIZE_MAN:0] o_special,
    output logic [SIZE_EXP+SIZE_MAN:0] o_op_a,
    output logic [SIZE_EXP+SIZE_MAN:0] o_op_b,
    output logic [1:0]                 o_mode,
    output logic [TAG_W-1:0]           o_tag,
    output logic                       o_invalid,
    input  logic                       i_flag_clr,
    output logic                       o_invalid_sticky
);

    localparam int unsigned W = 1 + SIZE_EXP + SIZE_MAN;
    localparam logic [W-1:0] QNAN = {1'b0, {SIZE_EXP{1'b1}}, 1'b1, {(SIZE_MAN-1){1'b0}}};

    // Stage 1 state
    logic             s1_valid_q;
    logic [W-1:0]     s1_op_a_q, s1_op_b_q;
    logic [1:0]       s1_mode_q;
    logic [TAG_W-1:0] s1_tag_q;
    cls_e             s1_cls_a_q, s1_cls_b_q;

    // Stage 2 state
    logic             s2_valid_q;
    logic [W-1:0]     s2_op_a_q, s2_op_b_q;
    logic [1:0]       s2_mode_q;
    logic [TAG_W-1:0] s2_tag_q;
    sel_e             s2_sel_q;
    logic [W-1:0]     s2_special_q;
    logic             s2_invalid_q;
    logic             sticky_q;

    // Classifier outputs and stage-2 next state
    cls_e         cls_a_c, cls_b_c;
    logic [W-1:0] op_a_fwd_c, op_b_fwd_c;
    sel_e         sel_d;
    logic [W-1:0] special_d;
    logic         invalid_d;
    logic         sticky_d;

    logic s1_advance;
    logic out_hs;

    assign s1_advance = ~s2_valid_q | i_ready;
    assign o_ready    = ~s1_valid_q | s1_advance;
    assign out_hs     = s2_valid_q & i_ready;

    fpu_operand_classify #(.SIZE_EXP(SIZE_EXP), .SIZE_MAN(SIZE_MAN)) u_cls_a (
        .op_i  (i_op_a),
        .cls_c (cls_a_c),
        .op_c  (op_a_fwd_c)
    );

    fpu_operand_classify #(.SIZE_EXP(SIZE_EXP), .SIZE_MAN(SIZE_MAN)) u_cls_b (
        .op_i  (i_op_b),
        .cls_c (cls_b_c),
        .op_c  (op_b_fwd_c)
    );

    // Stage 1 register: capture operands and classes when the slot frees
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_op_a_q  <= '0;
            s1_op_b_q  <= '0;
            s1_mode_q  <= '0;
            s1_tag_q   <= '0;
            s1_cls_a_q <= CLS_ZERO;
            s1_cls_b_q <= CLS_ZERO;
        end else if (o_ready) begin
            s1_valid_q <= i_valid;
            s1_op_a_q  <= op_a_fwd_c;
            s1_op_b_q  <= op_b_fwd_c;
            s1_mode_q  <= i_mode;
            s1_tag_q   <= i_tag;
            s1_cls_a_q <= cls_a_c;
            s1_cls_b_q <= cls_b_c;
        end
    end

    logic sa, sb, sb_eff, sx, addsub;
    logic a_zero, b_zero, a_inf, b_inf, any_nan;

    assign addsub  = is_addsub(s1_mode_q);
    assign sa      = s1_op_a_q[W-1];
    assign sb      = s1_op_b_q[W-1];
    assign sb_eff  = sb ^ (s1_mode_q == MODE_SUB);
    assign sx      = sa ^ sb;
    assign a_zero  = (s1_cls_a_q == CLS_ZERO);
    assign b_zero  = (s1_cls_b_q == CLS_ZERO);
    assign a_inf   = (s1_cls_a_q == CLS_INF);
    assign b_inf   = (s1_cls_b_q == CLS_INF);
    assign any_nan = (s1_cls_a_q == CLS_NAN) | (s1_cls_b_q == CLS_NAN);

    // Special-case rule tables, first match wins
    always_comb begin
        sel_d     = SEL_NORMAL;
        special_d = '0;
        invalid_d = 1'b0;
        if (any_nan) begin
            sel_d     = SEL_NAN;
            special_d = QNAN;
        end else if (!addsub) begin
            if ((a_inf & b_zero) | (a_zero & b_inf)) begin
                sel_d     = SEL_NAN;
                special_d = QNAN;
                invalid_d = 1'b1;
            end else if (a_inf | b_inf) begin
                sel_d     = SEL_INF;
                special_d = {sx, {SIZE_EXP{1'b1}}, {SIZE_MAN{1'b0}}};
            end else if (a_zero | b_zero) begin
                sel_d     = SEL_ZERO;
                special_d = {sx, {(W-1){1'b0}}};
            end
        end else begin
            if (a_inf & b_inf & (sa != sb_eff)) begin
                sel_d     = SEL_NAN;
                special_d = QNAN;
                invalid_d = 1'b1;
            end else if (a_inf) begin
                sel_d     = SEL_INF;
                special_d = {sa, {SIZE_EXP{1'b1}}, {SIZE_MAN{1'b0}}};
            end else if (b_inf) begin
                sel_d     = SEL_INF;
                special_d = {sb_eff, {SIZE_EXP{1'b1}}, {SIZE_MAN{1'b0}}};
            end else if (a_zero & b_zero) begin
                sel_d     = SEL_ZERO;
                special_d = {sa & sb_eff, {(W-1){1'b0}}};
            end else if (a_zero) begin
                sel_d     = SEL_PASS_B;
                special_d = {sb_eff, s1_op_b_q[W-2:0]};
            end else if (b_zero) begin
                sel_d     = SEL_PASS_A;
                special_d = s1_op_a_q;
            end
        end
    end

    // Stage 2 register: capture decision when output slot empties or drains
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid_q   <= 1'b0;
            s2_op_a_q    <= '0;
            s2_op_b_q    <= '0;
            s2_mode_q    <= '0;
            s2_tag_q     <= '0;
            s2_sel_q     <= SEL_NORMAL;
            s2_special_q <= '0;
            s2_invalid_q <= 1'b0;
        end else if (s1_advance) begin
            s2_valid_q   <= s1_valid_q;
            s2_op_a_q    <= s1_op_a_q;
            s2_op_b_q    <= s1_op_b_q;
            s2_mode_q    <= s1_mode_q;
            s2_tag_q     <= s1_tag_q;
            s2_sel_q     <= sel_d;
            s2_special_q <= special_d;
            s2_invalid_q <= invalid_d;
        end
    end

    // Sticky invalid next state: set on invalid handshake beats clear
    always_comb begin
        sticky_d = sticky_q;
        if (i_flag_clr) sticky_d = 1'b0;
        if (out_hs & s2_invalid_q) sticky_d = 1'b1;
    end

    // Sticky invalid register
    always_ff @(posedge i_clk) begin
        if (i_rst) sticky_q <= 1'b0;
        else       sticky_q <= sticky_d;
    end

    assign o_valid          = s2_valid_q;
    assign o_sel            = s2_sel_q;
    assign o_special        = s2_special_q;
    assign o_op_a           = s2_op_a_q;
    assign o_op_b           = s2_op_b_q;
    assign o_mode           = s2_mode_q;
    assign o_tag            = s2_tag_q;
    assign o_invalid        = s2_invalid_q;
    assign o_invalid_sticky = sticky_q;

endmodule

// File: tb/tb_fpu_special_case_pipe.sv
// Scoreboard bench for fpu_special_case_pipe (single precision, 4-bit tag).
module tb_fpu_special_case_pipe;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] special;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [1:0]  mode;
        logic [3:0]  tag;
        logic        invalid;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_mode = '0;
    logic [31:0] i_op_a = '0;
    logic [31:0] i_op_b = '0;
    logic [3:0]  i_tag = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [2:0]  o_sel;
    logic [31:0] o_special;
    logic [31:0] o_op_a;
    logic [31:0] o_op_b;
    logic [1:0]  o_mode;
    logic [3:0]  o_tag;
    logic        o_invalid;
    logic        i_flag_clr = 1'b0;
    logic        o_invalid_sticky;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    exp_t sb[$];

    fpu_special_case_pipe #(.SIZE_EXP(8), .SIZE_MAN(23), .TAG_W(4)) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_mode           (i_mode),
        .i_op_a           (i_op_a),
        .i_op_b           (i_op_b),
        .i_tag            (i_tag),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_sel            (o_sel),
        .o_special        (o_special),
        .o_op_a           (o_op_a),
        .o_op_b           (o_op_b),
        .o_mode           (o_mode),
        .o_tag            (o_tag),
        .o_invalid        (o_invalid),
        .i_flag_clr       (i_flag_clr),
        .o_invalid_sticky (o_invalid_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int C_ZERO = 0, C_SUB = 1, C_NORM = 2, C_INF = 3, C_NAN = 4;

    function automatic int classify(input logic [31:0] x);
        int e = int'(x[30:23]);
        int m = int'(x[22:0]);
        if (e == 255) return (m == 0) ? C_INF : C_NAN;
        if (e != 0)   return C_NORM;
        if (m == 0)   return C_ZERO;
`ifdef FPU_PSC_FTZ_EN
        return C_ZERO;
`else
        return C_SUB;
`endif
    endfunction

    function automatic logic [31:0] fwd(input logic [31:0] x);
`ifdef FPU_PSC_FTZ_EN
        if (x[30:23] == 8'd0) return x & 32'h8000_0000;
`endif
        return x;
    endfunction

    function automatic exp_t model(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int ca = classify(a);
        int cb = classify(b);
        bit sa = a[31];
        bit sbe = b[31] ^ (mode == 2'd2);
        bit sx = a[31] ^ b[31];
        bit addsub = (mode == 2'd1) || (mode == 2'd2);
        r.op_a = fwd(a); r.op_b = fwd(b); r.mode = mode; r.tag = '0;
        r.acc_cyc = 0; r.chk_lat = 0;
        r.sel = 3'd0; r.special = 32'h0; r.invalid = 1'b0;
        if (ca == C_NAN || cb == C_NAN) begin
            r.sel = 3'd3; r.special = 32'h7FC0_0000;
        end else if (!addsub) begin
            if ((ca == C_INF || cb == C_INF) && (ca == C_ZERO || cb == C_ZERO)) begin
                r.sel = 3'd3; r.special = 32'h7FC0_0000; r.invalid = 1'b1;
            end else if (ca == C_INF || cb == C_INF) begin
                r.sel = 3'd2; r.special = {sx, 31'h7F80_0000};
            end else if (ca == C_ZERO || cb == C_ZERO) begin
                r.sel = 3'd1; r.special = {sx, 31'h0};
            end
        end else begin
            if (ca == C_INF && cb == C_INF && sa != sbe) begin
                r.sel = 3'd3; r.special = 32'h7FC0_0000; r.invalid = 1'b1;
            end else if (ca == C_INF) begin
                r.sel = 3'd2; r.special = {sa, 31'h7F80_0000};
            end else if (cb == C_INF) begin
                r.sel = 3'd2; r.special = {sbe, 31'h7F80_0000};
            end else if (ca == C_ZERO && cb == C_ZERO) begin
                r.sel = 3'd1; r.special = {sa & sbe, 31'h0};
            end else if (ca == C_ZERO) begin
                r.sel = 3'd5; r.special = {sbe, b[30:0]};
            end else if (cb == C_ZERO) begin
                r.sel = 3'd4; r.special = a;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] x;
        logic s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0: x = {s, 31'h0};
            1: x = {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
            2: x = {s, 8'($urandom_range(1, 254)), 23'($urandom)};
            3: x = {s, 8'hFF, 23'h0};
            4: x = {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
            default: x = $urandom;
        endcase
        return x;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t, input logic rdy,
                         input logic clr, input logic rst, input exp_t e, input bit lat,
                         output bit acc);
        exp_t ee;
        @(posedge clk);
        #1;
        i_valid = v; i_mode = m; i_op_a = a; i_op_b = b; i_tag = t;
        i_ready = rdy; i_flag_clr = clr; i_rst = rst;
        @(negedge clk);
        acc = v && o_ready && !rst;
        if (acc) begin
            ee = e; ee.tag = t; ee.acc_cyc = cyc; ee.chk_lat = lat;
            sb.push_back(ee);
        end
    endtask

    task automatic idle(input logic rdy);
        exp_t e;
        bit acc;
        e = model(2'd0, 32'h0, 32'h0);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0, rdy, 1'b0, 1'b0, e, 1'b0, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            idle(1'b1);
            n++;
        end
        chk("drain_empty", 128'(sb.size()), 128'd0);
    endtask

    // ---------------- monitor ----------------
    exp_t   me;
    bit     hs;
    bit     hold_v = 0;
    logic [105:0] hold_d;
    logic   sticky_m = 1'b0;
    logic   inv_seen;

    always @(negedge clk) begin
        if (i_rst) begin
            sb.delete();
            sticky_m = 1'b0;
            hold_v   = 0;
        end else begin
            chk("sticky", 128'(o_invalid_sticky), 128'(sticky_m));
            if (hold_v) begin
                chk("stall_valid", 128'(o_valid), 128'd1);
                chk("stall_hold", 128'({o_sel, o_special, o_op_a, o_op_b, o_mode, o_tag, o_invalid}),
                    128'(hold_d));
            end
            hs = o_valid && i_ready;
            inv_seen = 1'b0;
            if (hs) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 128'(o_tag), 128'hFFFF);
                end else begin
                    me = sb.pop_front();
                    inv_seen = me.invalid;
                    chk("sel",     128'(o_sel),     128'(me.sel));
                    chk("special", 128'(o_special), 128'(me.special));
                    chk("op_a",    128'(o_op_a),    128'(me.op_a));
                    chk("op_b",    128'(o_op_b),    128'(me.op_b));
                    chk("mode",    128'(o_mode),    128'(me.mode));
                    chk("tag",     128'(o_tag),     128'(me.tag));
                    chk("invalid", 128'(o_invalid), 128'(me.invalid));
                    if (me.chk_lat) chk("latency", 128'(cyc - me.acc_cyc), 128'd2);
                end
            end
            if (hs && inv_seen) sticky_m = 1'b1;
            else if (i_flag_clr) sticky_m = 1'b0;
            hold_v = o_valid && !i_ready;
            hold_d = {o_sel, o_special, o_op_a, o_op_b, o_mode, o_tag, o_invalid};
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [31:0] special;
        logic        inv;
        logic [31:0] fa;
    } dvec_t;

    dvec_t dv[11];

    initial begin
        exp_t e;
        bit acc;
        int r;

        dv[0]  = '{2'd0, 32'h7F80_0000, 32'h0000_0000, 3'd3, 32'h7FC0_0000, 1'b1, 32'h7F80_0000};
        dv[1]  = '{2'd0, 32'hBF80_0000, 32'h7F80_0000, 3'd2, 32'hFF80_0000, 1'b0, 32'hBF80_0000};
        dv[2]  = '{2'd2, 32'h7F80_0000, 32'h7F80_0000, 3'd3, 32'h7FC0_0000, 1'b1, 32'h7F80_0000};
        dv[3]  = '{2'd1, 32'h7F80_0000, 32'h7F80_0000, 3'd2, 32'h7F80_0000, 1'b0, 32'h7F80_0000};
        dv[4]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 3'd1, 32'h8000_0000, 1'b0, 32'h8000_0000};
        dv[5]  = '{2'd2, 32'h0000_0000, 32'h4040_0000, 3'd5, 32'hC040_0000, 1'b0, 32'h0000_0000};
        dv[6]  = '{2'd1, 32'h3F80_0000, 32'h0000_0000, 3'd4, 32'h3F80_0000, 1'b0, 32'h3F80_0000};
        dv[7]  = '{2'd0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 32'h0000_0000, 1'b0, 32'h3F80_0000};
        dv[8]  = '{2'd0, 32'h7FC1_2345, 32'h0000_0000, 3'd3, 32'h7FC0_0000, 1'b0, 32'h7FC1_2345};
        dv[9]  = '{2'd3, 32'h0000_0000, 32'hC000_0000, 3'd1, 32'h8000_0000, 1'b0, 32'h0000_0000};
`ifdef FPU_PSC_FTZ_EN
        dv[10] = '{2'd0, 32'h0000_0001, 32'h7F80_0000, 3'd3, 32'h7FC0_0000, 1'b1, 32'h0000_0000};
`else
        dv[10] = '{2'd0, 32'h0000_0001, 32'h7F80_0000, 3'd2, 32'h7F80_0000, 1'b0, 32'h0000_0001};
`endif

        // Reset and check reset state
        e = model(2'd0, 32'h0, 32'h0);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, e, 1'b0, acc);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, e, 1'b0, acc);
        idle(1'b1);
        chk("rst_valid",   128'(o_valid),          128'd0);
        chk("rst_ready",   128'(o_ready),          128'd1);
        chk("rst_sel",     128'(o_sel),            128'd0);
        chk("rst_special", 128'(o_special),        128'd0);
        chk("rst_ops",     128'({o_op_a, o_op_b}), 128'd0);
        chk("rst_tag",     128'({o_mode, o_tag}),  128'd0);
        chk("rst_inv",     128'(o_invalid),        128'd0);
        chk("rst_sticky",  128'(o_invalid_sticky), 128'd0);

        // Directed special cases with known results
        for (int i = 0; i < 11; i++) begin
            e.sel = dv[i].sel; e.special = dv[i].special; e.invalid = dv[i].inv;
            e.op_a = dv[i].fa; e.op_b = dv[i].b; e.mode = dv[i].mode;
            drive(1'b1, dv[i].mode, dv[i].a, dv[i].b, 4'(i), 1'b1, 1'b0, 1'b0, e, 1'b1, acc);
            chk("directed_accept", 128'(acc), 128'd1);
        end
        drain();
        chk("sticky_after_invalid", 128'(o_invalid_sticky), 128'd1);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, e, 1'b0, acc);
        idle(1'b1);
        chk("sticky_cleared", 128'(o_invalid_sticky), 128'd0);

        // Back-to-back streaming, tags 0..7
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a = rnd_op();
            logic [31:0] b = rnd_op();
            logic [1:0]  m = 2'($urandom_range(0, 3));
            e = model(m, a, b);
            drive(1'b1, m, a, b, 4'(i), 1'b1, 1'b0, 1'b0, e, (i < 6), acc);
            chk("stream_accept", 128'(acc), 128'd1);
        end
        // Stall with a full pipe
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a = rnd_op();
            logic [31:0] b = rnd_op();
            e = model(2'd1, a, b);
            drive(1'b1, 2'd1, a, b, 4'(8 + i), 1'b0, 1'b0, 1'b0, e, 1'b0, acc);
            chk("stall_ready", 128'(o_ready), 128'd0);
        end
        drain();

        // Reset mid-stream discards in-flight beats
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a = rnd_op();
            logic [31:0] b = rnd_op();
            e = model(2'd0, a, b);
            drive(1'b1, 2'd0, a, b, 4'(i), 1'b1, 1'b0, 1'b0, e, 1'b0, acc);
        end
        drive(1'b1, 2'd0, 32'h7F80_0000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, e, 1'b0, acc);
        idle(1'b1);
        chk("midrst_valid",  128'(o_valid),          128'd0);
        chk("midrst_sticky", 128'(o_invalid_sticky), 128'd0);
        idle(1'b1);
        chk("midrst_drained", 128'(o_valid), 128'd0);

        // Randomized traffic with backpressure, clears and occasional reset
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a = rnd_op();
            logic [31:0] b = rnd_op();
            logic [1:0]  m = 2'($urandom_range(0, 3));
            logic v   = ($urandom_range(0, 3) != 0);
            logic rdy = ($urandom_range(0, 3) != 0);
            logic clr = ($urandom_range(0, 15) == 0);
            logic rst = ($urandom_range(0, 149) == 0);
            r = i;
            e = model(m, a, b);
            drive(v, m, a, b, 4'(r), rdy, clr, rst, e, 1'b0, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
